debounce_nch: RTL and testbench

Parametrised multi-channel debouncer for mechanical switch and button inputs. Each channel synchronises its asynchronous input and applies a symmetric debounce on both rising and falling transitions: a glitch shorter than N_TICS samples is rejected in either direction. It produces a clean level plus single-cycle rise and fall event pulses. It sits between board-level pins and the control FSMs, and supersedes the single-channel, rise-only 3-tic debouncer.

---
 rtl/db_pkg.sv | 16 +
 rtl/debounce_ch.sv | 106 ++++++++++
 rtl/debounce_nch.sv | 33 +++
 tb/tb_debounce_nch.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/db_pkg.sv
// Shared types and sizing helpers for the multi-channel debouncer.
package db_pkg;

  typedef enum logic [1:0] {
    LOW      = 2'b00,
    RISE_CHK = 2'b01,
    HIGH     = 2'b10,
    FALL_CHK = 2'b11
  } db_state_e;

  // Counter width able to hold 0..n.
  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// One debouncer channel: input synchroniser, symmetric check FSM,
// stability counter and registered rise/fall event pulses.
module debounce_ch
  import db_pkg::*;
#(
  parameter int unsigned N_TICS      = 3,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic ce_i,
  input  logic x_i,
  output logic y_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned CNT_W = cnt_w(N_TICS);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   x_s;
  db_state_e              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  assign x_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      state_q <= LOW;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], x_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (ce_i) begin
      case (state_q)
        LOW: begin
          if (x_s) begin
            state_d = RISE_CHK;
            cnt_d   = CNT_W'(1);
          end else begin
            cnt_d = '0;
          end
        end
        RISE_CHK: begin
          if (!x_s) begin
            state_d = LOW;
            cnt_d   = '0;
          end else if (cnt_q == CNT_W'(N_TICS - 1)) begin
            state_d = HIGH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        HIGH: begin
          if (!x_s) begin
            state_d = FALL_CHK;
            cnt_d   = CNT_W'(1);
          end else begin
            cnt_d = '0;
          end
        end
        FALL_CHK: begin
          if (x_s) begin
            state_d = HIGH;
            cnt_d   = '0;
          end else if (cnt_q == CNT_W'(N_TICS - 1)) begin
            state_d = LOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = LOW;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Pulses mark the accepting edge so they line up with the first new y value.
  always_comb begin
    rise_d = (state_q == RISE_CHK) && (state_d == HIGH);
    fall_d = (state_q == FALL_CHK) && (state_d == LOW);
  end

  assign y_o    = (state_q == HIGH) || (state_q == FALL_CHK);
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/debounce_nch.sv
// N-channel debouncer: independent debounce_ch instances, one per input bit.
module debounce_nch
  import db_pkg::*;
#(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned N_TICS      = 3,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ce,
  input  logic [N_CH-1:0] x,
  output logic [N_CH-1:0] y,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_ch #(
      .N_TICS      (N_TICS),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .ce_i   (ce),
      .x_i    (x[i]),
      .y_o    (y[i]),
      .rise_o (rise[i]),
      .fall_o (fall[i])
    );
  end

endmodule

// File: tb/tb_debounce_nch.sv
// Scoreboard bench for debounce_nch: two instances (N_TICS=3 and 5) against a
// run-length reference model of the debounce rules.
module tb_debounce_nch;

  typedef struct packed {
    logic [3:0] y;
    logic [3:0] rise;
    logic [3:0] fall;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ce  = 1'b1;
  logic [3:0] x   = '0;
  logic [3:0] ya, ra, fa, yb, rb, fb;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int ce_mode = 0;

  exp_t exp_a[$];
  exp_t exp_b[$];

  always #5 clk = ~clk;

  debounce_nch #(.N_CH(4), .N_TICS(3), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .rst(rst), .ce(ce), .x(x), .y(ya), .rise(ra), .fall(fa));

  debounce_nch #(.N_CH(4), .N_TICS(5), .SYNC_STAGES(2)) dut_b (
    .clk(clk), .rst(rst), .ce(ce), .x(x), .y(yb), .rise(rb), .fall(fb));

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  // Reference: a channel flips its level once it has seen N consecutive
  // ce-qualified samples disagreeing with it; the synchronised input is the
  // raw input as it stood two clock edges earlier.
  int unsigned run[2][4];
  bit          ym[2][4];
  logic [3:0]  hist[$] = '{4'h0, 4'h0};

  always @(posedge clk) begin
    exp_t       e[2];
    logic [3:0] xs;
    int unsigned nt;
    if (rst) begin
      foreach (run[i, c]) begin
        run[i][c] = 0;
        ym[i][c]  = 1'b0;
      end
      hist = '{4'h0, 4'h0};
      exp_a.push_back('0);
      exp_b.push_back('0);
    end else begin
      xs = hist.pop_front();
      hist.push_back(x);
      for (int i = 0; i < 2; i++) begin
        nt = (i == 0) ? 3 : 5;
        e[i] = '0;
        for (int c = 0; c < 4; c++) begin
          if (ce) begin
            if (xs[c] != ym[i][c]) begin
              run[i][c]++;
              if (run[i][c] == nt) begin
                ym[i][c] = ~ym[i][c];
                run[i][c] = 0;
                if (ym[i][c]) e[i].rise[c] = 1'b1;
                else          e[i].fall[c] = 1'b1;
              end
            end else begin
              run[i][c] = 0;
            end
          end
          e[i].y[c] = ym[i][c];
        end
      end
      exp_a.push_back(e[0]);
      exp_b.push_back(e[1]);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (exp_a.size() > 0) begin
      e = exp_a.pop_front();
      chk("A.y", ya, e.y);
      chk("A.rise", ra, e.rise);
      chk("A.fall", fa, e.fall);
    end
    if (exp_b.size() > 0) begin
      e = exp_b.pop_front();
      chk("B.y", yb, e.y);
      chk("B.rise", rb, e.rise);
      chk("B.fall", fb, e.fall);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
      cyc++;
      case (ce_mode)
        1:       ce = (cyc % 10 == 0);
        2:       ce = ($urandom_range(0, 3) != 0);
        default: ce = 1'b1;
      endcase
    end
  endtask

  // Edge index (0 = first edge after the call) of the first rise pulse
  // within mask on each instance, plus the rise vector seen at that edge.
  task automatic measure(input logic [3:0] mask, output int la, output int lb,
                         output logic [3:0] va, output logic [3:0] vb);
    la = -1; lb = -1; va = '0; vb = '0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      #1;
      if (la < 0 && (ra & mask) != 0) begin la = n; va = ra; end
      if (lb < 0 && (rb & mask) != 0) begin lb = n; vb = rb; end
    end
  endtask

  initial begin
    int la, lb;
    logic [3:0] va, vb;

    step(3);
    chk("reset.y", {ya, yb}, 0);
    chk("reset.pulses", {ra, fa, rb, fb}, 0);
    rst = 1'b0;
    step(3);

    // Clean press on ch0
    x[0] = 1'b1;
    measure(4'b0001, la, lb, va, vb);
    chk("press.latA", la, 4);
    chk("press.latB", lb, 6);
    chk("press.onlych0", va, 4'b0001);
    step(2);

    // Bounce on ch1: 2 high, 1 low, then held
    x[1] = 1'b1; step(2);
    x[1] = 1'b0; step(1);
    x[1] = 1'b1;
    measure(4'b0010, la, lb, va, vb);
    chk("bounce.latA", la, 4);
    chk("bounce.latB", lb, 6);
    step(2);

    // Release glitches on ch2
    x[2] = 1'b1; step(12);
    x[2] = 1'b0; step(2);
    x[2] = 1'b1; step(10);
    x[2] = 1'b0; step(3);
    x[2] = 1'b1; step(10);
    x[2] = 1'b0; step(12);

    // Enable gating on ch3
    ce_mode = 1;
    x[3] = 1'b1; step(70);
    x[3] = 1'b0; step(70);
    ce_mode = 0;
    step(2);

    // Reset while ch0 is High and ch1 is mid rise-check
    x[1] = 1'b0; step(12);
    x[1] = 1'b1; step(4);
    rst = 1'b1;
    #1;
    chk("rst.async.A", {ya, ra, fa}, 0);
    chk("rst.async.B", {yb, rb, fb}, 0);
    step(2);
    rst = 1'b0;
    measure(4'b0010, la, lb, va, vb);
    chk("rst.rerise.latA", la, 4);
    chk("rst.rerise.latB", lb, 6);
    step(2);

    // All channels together
    x = 4'h0; step(12);
    x = 4'hF;
    measure(4'hF, la, lb, va, vb);
    chk("simul.latA", la, 4);
    chk("simul.latB", lb, 6);
    chk("simul.allA", va, 4'hF);
    chk("simul.allB", vb, 4'hF);
    step(2);

    // Randomised bouncing inputs, with and without ce strobing
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) ce_mode = 2;
      if (n == 2200) rst = 1'b1;
      if (n == 2202) rst = 1'b0;
      for (int c = 0; c < 4; c++)
        if ($urandom_range(0, 7) == 0) x[c] = ~x[c];
      step(1);
    end
    ce_mode = 0;
    step(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
